// File: rtl/ustream_decoder.sv
//------------------------------------------------------------------------------
// Module      : ustream_decoder
// Description : Stochastic bitstream decoder. On iStart it counts the ones in
//               a window of 2^BITWIDTH accepted (iValid) samples and publishes
//               the result on oResult with a one-cycle oDone pulse.
//               Optional macro USTREAM_DEC_BIPOLAR_EN selects the bipolar
//               output encoding (2*ones - 2^BITWIDTH); when the macro is
//               undefined the result is the plain ones count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ustream_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iValid,
  input  logic                iBit,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH+1:0] oResult
);

  // Sample index of the last sample in a window (2^BITWIDTH - 1).
  localparam logic [BITWIDTH:0] CNT_LAST = {1'b0, {BITWIDTH{1'b1}}};
`ifdef USTREAM_DEC_BIPOLAR_EN
  // Window length at result width, used as the bipolar zero offset.
  localparam logic [BITWIDTH+1:0] WINDOW_EXT = {2'b01, {BITWIDTH{1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  // Both counters carry one extra bit so a full window never wraps.
  logic [BITWIDTH:0]   ones_q;
  logic [BITWIDTH:0]   cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BITWIDTH+1:0] result_q;

  logic [BITWIDTH:0]   ones_d;
  logic                last_d;
  logic [BITWIDTH+1:0] result_d;

  // Ones count including the current sample, and the encoded result it yields.
  always_comb begin
    ones_d = ones_q + {{BITWIDTH{1'b0}}, iBit};
    last_d = (cnt_q == CNT_LAST);
`ifdef USTREAM_DEC_BIPOLAR_EN
    result_d = {ones_d, 1'b0} - WINDOW_EXT;
`else
    result_d = {1'b0, ones_d};
`endif
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            ones_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (iValid) begin
            ones_q <= ones_d;
            cnt_q  <= cnt_q + {{BITWIDTH{1'b0}}, 1'b1};
            if (last_d) begin
              // The final sample is folded into the latched result.
              result_q <= result_d;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ustream_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_ustream_decoder
// Description : Self-checking bench for ustream_decoder at BITWIDTH=4.
//               Honours USTREAM_DEC_BIPOLAR_EN for the expected encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ustream_decoder;

  localparam int BITWIDTH = 4;
  localparam int WIN      = 1 << BITWIDTH;

  logic                iClk;
  logic                iRst;
  logic                iStart;
  logic                iValid;
  logic                iBit;
  logic                oBusy;
  logic                oDone;
  logic [BITWIDTH+1:0] oResult;

  int checks;
  int errors;

  ustream_decoder #(.BITWIDTH(BITWIDTH)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iValid  (iValid),
    .iBit    (iBit),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: count the ones in the window and apply the output encoding.
  function automatic logic [BITWIDTH+1:0] ref_result(input logic [WIN-1:0] bits);
    int n;
    n = 0;
    for (int k = 0; k < WIN; k++) n += int'(bits[k]);
`ifdef USTREAM_DEC_BIPOLAR_EN
    return (BITWIDTH+2)'(2 * n - WIN);
`else
    return (BITWIDTH+2)'(n);
`endif
  endfunction

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // One full conversion window.
  // gap_mode: 0 = no gaps, 1 = iValid low every third cycle, 2 = random gaps.
  // start_at: sample index on which iStart is also pulsed (-1 = never).
  task automatic run_window(input logic [WIN-1:0] bits, input int gap_mode,
                            input int start_at, input bit start_in_done);
    int idx;
    int cyc;
    bit vld;
    logic [BITWIDTH+1:0] exp;
    exp    = ref_result(bits);
    iStart = 1'b1;
    iValid = 1'b0;
    iBit   = 1'($urandom);
    tick();
    check("busy_after_start", 32'(oBusy), 32'd1);
    iStart = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < WIN) begin
      case (gap_mode)
        1:       vld = (cyc % 3) != 2;
        2:       vld = $urandom_range(0, 3) != 0;
        default: vld = 1'b1;
      endcase
      iValid = vld;
      iBit   = vld ? bits[idx] : 1'($urandom);
      iStart = (idx == start_at);
      tick();
      cyc++;
      if (vld) idx++;
      if (idx < WIN) begin
        check("busy_in_run", 32'(oBusy), 32'd1);
        check("no_early_done", 32'(oDone), 32'd0);
      end
    end
    iValid = 1'b0;
    iStart = start_in_done;
    check("done_pulse", 32'(oDone), 32'd1);
    check("busy_in_done", 32'(oBusy), 32'd0);
    check("result", 32'(oResult), 32'(exp));
    tick();
    iStart = 1'b0;
    check("done_one_cycle", 32'(oDone), 32'd0);
    check("idle_after_done", 32'(oBusy), 32'd0);
    check("result_held", 32'(oResult), 32'(exp));
  endtask

  initial begin
    logic [WIN-1:0] bits;
    logic [15:0]    lfsr;
    logic           fb;
    int             pos;

    checks = 0;
    errors = 0;
    iRst   = 1'b1;
    iStart = 1'b0;
    iValid = 1'b0;
    iBit   = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_result", 32'(oResult), 32'd0);
    iRst = 1'b0;

    // Samples offered while idle must not be counted.
    iValid = 1'b1;
    iBit   = 1'b1;
    tick();
    tick();
    check("idle_ignores_valid", 32'(oBusy), 32'd0);

    // All ones, then back-to-back alternating with gaps, then all zeros.
    run_window({WIN{1'b1}}, 0, -1, 1'b0);
    run_window({(WIN/2){2'b01}}, 1, -1, 1'b0);
    run_window({WIN{1'b0}}, 0, -1, 1'b0);

    // Extra iStart on sample 5 and in DONE; next idle start opens a second window.
    run_window(WIN'($urandom), 0, 5, 1'b1);
    run_window(WIN'($urandom), 2, -1, 1'b0);

    // Leave a nonzero result, then abort a window with reset after 10 ones.
    run_window({WIN{1'b1}}, 0, -1, 1'b0);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    iValid = 1'b1;
    iBit   = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    #2;
    iRst = 1'b1;
    #1;
    check("async_rst_busy", 32'(oBusy), 32'd0);
    check("async_rst_done", 32'(oDone), 32'd0);
    check("async_rst_result", 32'(oResult), 32'd0);
    tick();
    iRst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("no_done_after_abort", 32'(oDone), 32'd0);
    end
    iValid = 1'b0;
    // Four ones scattered over the window.
    bits = '0;
    while ($countones(bits) < 4) begin
      pos = $urandom_range(0, WIN - 1);
      bits[pos] = 1'b1;
    end
    run_window(bits, 0, -1, 1'b0);

    // Biased source, P(1)=0.75, from a fixed-seed LFSR.
    lfsr = 16'hACE1;
    for (int k = 0; k < WIN; k++) begin
      fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      lfsr    = {lfsr[14:0], fb};
      bits[k] = lfsr[0] | lfsr[1];
    end
    run_window(bits, 1, -1, 1'b0);

    // Random windows with random gaps.
    for (int w = 0; w < 6; w++) begin
      run_window(WIN'($urandom), 2, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
